pwm_pair_encoder: RTL
=====================

// Module: pwm_pair_encoder
// PURPOSE
//  Downstream of the per-pixel painter. Consumes 24-bit RGB pixels, one per accepted beat,
//   in top-half/bottom-half pairs for the two simultaneously driven panel rows.
//  Compares each 8-bit colour component against the current PWM subframe threshold.
//  Emits one 6-bit {R0,G0,B0,R1,G1,B1} word per pair to the panel shift-out stage.
// PARAMETERS
//  CBITS   8   colour component / subframe width; rgb input is 3*CBITS wide
// PORTS
//  clk         in   1        system clock; all state on rising edge
//  resetn      in   1        reset, asynchronous assert, active-low
//  subframe    in   CBITS    current PWM threshold from the frame/subframe counter
//  in_valid    in   1        pixel beat valid
//  in_ready    out  1        pixel beat accepted when in_valid && in_ready
//  in_rgb      in   3*CBITS  {red,green,blue}, MSB-first
//  in_half     in   1        0 = top-half pixel, 1 = bottom-half pixel
//  in_last     in   1        last pair of a row; meaningful on the bottom beat only
//  out_valid   out  1        output word valid
//  out_ready   in   1        downstream accepts when out_valid && out_ready
//  out_rgb6    out  6        {R0,G0,B0,R1,G1,B1} on/off bits
//  out_last    out  1        copy of in_last of the bottom beat
//  seq_err     out  1        sticky: half-sequence violation seen since reset
// BEHAVIOUR
//  Reset: state=WAIT_TOP; out_valid=0, out_rgb6=0, out_last=0, seq_err=0; top latch=0, sub latch=0.
//  FSM WAIT_TOP:
//   - in_ready=1.
//   - Accept with in_half=0: latch in_rgb to top reg, latch subframe to sub reg, go WAIT_BOT.
//   - Accept with in_half=1: beat dropped, seq_err<=1, stay.
//  FSM WAIT_BOT:
//   - in_ready = !out_valid || out_ready.
//   - Accept with in_half=1: compute the output word, go WAIT_TOP.
//   - Accept with in_half=0: treat as a new top; re-latch top and sub, seq_err<=1, stay.
//  Compare: bit = (component > sub), unsigned, strict. Component 0 is never on.
//   Component 2^CBITS-1 is on for every subframe except 2^CBITS-1.
//   Both halves compare against the sub value latched with the top beat, not the live subframe.
//  Output register:
//   - Loaded on the cycle after the bottom beat is accepted; latency 1 clk.
//   - out_valid held until out_ready.
//   - out_rgb6/out_last stable while out_valid && !out_ready.
//   - Load and drain in the same cycle: new word replaces old, out_valid stays 1; full throughput.
//  Top beat may be accepted while an output word is pending; it does not touch the output register.
//  Async reset mid-pair discards the latched top and any pending output.
// CONFIGURATION
//  PWM_GAMMA_EN defined:
//   - Each component c becomes g = (c*c + c) >> CBITS before compare.
//   - Examples: 0->0, 128->64, 255->255.
//   - Top pixel stored post-gamma; bottom corrected combinationally; latency stays 1 clk.
//  PWM_GAMMA_EN undefined: raw components compared; no multipliers synthesised.
// TESTING
//  1. Top rgb=FF0000, bot=00FF00, subframe=7F, out_ready=1 -> 1 clk later out_rgb6=6'b100010, out_valid one cycle.
//  2. Top rgb=808080, sub=80, bot=818181 -> out_rgb6=6'b000111 (strict >). Change subframe to 00 between top and bot -> same result.
//  3. Hold out_ready=0 and send pair A then top+bot of B -> bottom of B stalls (in_ready=0), A held stable.
//     Release out_ready -> A then B, no loss.
//  4. Send bot beat in WAIT_TOP -> dropped, seq_err=1 and stays 1. Two consecutive tops -> second top used.
//  5. Assert resetn=0 after a top beat -> out_valid=0, seq_err=0. Next bottom beat alone -> seq_err=1, no output.
//  6. PWM_GAMMA_EN: top=808080, bot=000000, sub=3F -> 6'b111000. sub=40 -> 6'b000000.

Source files
------------

// File: rtl/pwm_pair_encoder.sv
// ----------------------------------------------------------------------------
// Module      : pwm_pair_encoder
// Description : Pairs top-half/bottom-half RGB pixel beats. Each colour
//               component is compared against the PWM subframe threshold
//               that was latched with the top beat. The result is one
//               registered {R0,G0,B0,R1,G1,B1} on/off word per pair.
//               Optional macro PWM_GAMMA_EN enables per-component gamma
//               correction g = (c*c + c) >> CBITS before the compare.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module pwm_pair_encoder #(
  parameter int CBITS = 8
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [CBITS-1:0]   subframe,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3*CBITS-1:0] in_rgb,
  input  logic               in_half,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [5:0]         out_rgb6,
  output logic               out_last,
  output logic               seq_err
);

  localparam logic [0:0] S_WAIT_TOP = 1'b0;
  localparam logic [0:0] S_WAIT_BOT = 1'b1;

  // Brightness transfer applied to every component before it is compared.
  // Without gamma this is the identity, so no multiplier is built.
  function automatic logic [CBITS-1:0] f_corr(input logic [CBITS-1:0] c);
`ifdef PWM_GAMMA_EN
    logic [2*CBITS-1:0] v;
    v = ({{CBITS{1'b0}}, c} * {{CBITS{1'b0}}, c}) + {{CBITS{1'b0}}, c};
    v = v >> CBITS;
    return v[CBITS-1:0];
`else
    return c;
`endif
  endfunction

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [3*CBITS-1:0] r_top;
  logic [CBITS-1:0]   r_sub;
  logic               r_out_valid;
  logic [5:0]         r_out_rgb6;
  logic               r_out_last;
  logic               r_seq_err;

  logic               w_accept;
  logic               w_top_beat;
  logic               w_bot_beat;
  logic               w_bad_beat;
  logic [3*CBITS-1:0] w_in_corr;
  logic [5:0]         w_word;

  assign w_accept   = in_valid && in_ready;
  // A top beat is latched in either state; a top beat in WAIT_BOT restarts the pair.
  assign w_top_beat = w_accept && !in_half;
  assign w_bot_beat = w_accept && in_half && (r_state == S_WAIT_BOT);
  assign w_bad_beat = w_accept && (in_half == (r_state == S_WAIT_TOP));

  // Per-component correction and compare; index 0 is red (the MSB slice).
  for (genvar i = 0; i < 3; i++) begin : g_cmp
    localparam int HI = (3 - i) * CBITS - 1;
    assign w_in_corr[HI -: CBITS] = f_corr(in_rgb[HI -: CBITS]);
    assign w_word[5 - i]          = (r_top[HI -: CBITS] > r_sub);
    assign w_word[2 - i]          = (w_in_corr[HI -: CBITS] > r_sub);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_WAIT_TOP;
    else         r_state <= w_state_nxt;
  end

  // FSM next-state: a top beat arms the pair, a bottom beat completes it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_TOP: if (w_top_beat) w_state_nxt = S_WAIT_BOT;
      S_WAIT_BOT: if (w_bot_beat) w_state_nxt = S_WAIT_TOP;
      default:    w_state_nxt = S_WAIT_TOP;
    endcase
  end

  // FSM outputs: only a bottom beat needs room in the output register.
  always_comb begin
    in_ready = 1'b1;
    case (r_state)
      S_WAIT_TOP: in_ready = 1'b1;
      S_WAIT_BOT: in_ready = !r_out_valid || out_ready;
      default:    in_ready = 1'b1;
    endcase
  end

  // Top pixel (already corrected) and its threshold are captured together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_top <= '0;
      r_sub <= '0;
    end else if (w_top_beat) begin
      r_top <= w_in_corr;
      r_sub <= subframe;
    end
  end

  // Output word register; a load in the same cycle as a drain keeps valid high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_out_valid <= 1'b0;
      r_out_rgb6  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_bot_beat) begin
      r_out_valid <= 1'b1;
      r_out_rgb6  <= w_word;
      r_out_last  <= in_last;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky flag for any beat whose half does not match the expected one.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)         r_seq_err <= 1'b0;
    else if (w_bad_beat) r_seq_err <= 1'b1;
  end

  assign out_valid = r_out_valid;
  assign out_rgb6  = r_out_rgb6;
  assign out_last  = r_out_last;
  assign seq_err   = r_seq_err;

endmodule

`default_nettype wire
